// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_e                 receiver FSM state encoding
//   UART_DATA_W                data bits per frame
//   UART_DEFAULT_CLKS_PER_BIT  50 MHz / 115200 baud
package uart_pkg;

  localparam int unsigned UART_DATA_W               = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, reusable by RX and TX paths.
// Ports:
//   clk, rst        clock, async active-high reset (pointers and storage cleared)
//   push, push_data write request and data; dropped when full unless popping
//   pop             read request; ignored when empty
//   head_c          head entry, read combinationally from storage
//   full_c, empty_c status derived from the registered pointers
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign head_c  = mem[rd_ptr[PTR_W-2:0]];

  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[PTR_W-2:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined)
// feeding a show-ahead FIFO drained by the core.
// Ports:
//   clk, rst    clock, async active-high reset
//   rxd         asynchronous serial input, idles high
//   uart_rdreq  pop one byte per asserted cycle
//   uart_in     FIFO head byte, valid while uart_empty is low
//   uart_empty  FIFO empty
//   frame_err   one-cycle pulse on bad stop bit or parity
//   overrun     one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DEPTH_LOG2   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  input  logic                   uart_rdreq,
  output logic [UART_DATA_W-1:0] uart_in,
  output logic                   uart_empty,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_W);
  // The IDLE cycle that detects the falling edge already counts toward the half bit.
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(UART_DATA_W - 1);

  rx_state_e              state_q, state_d;
  logic [1:0]             rxd_sync;
  logic                   rxd_s;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   push_q;
  logic                   fifo_full;
  logic                   pop_c;
  logic                   half_done;
  logic                   bit_done;
  logic                   par_ok;
  logic                   cnt_clr_c;
  logic                   shift_en_c;
  logic                   good_c;
  logic                   bad_c;

  // Two-flop synchronizer; resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rxd_sync <= 2'b11;
    else     rxd_sync <= {rxd_sync[0], rxd};
  end
  assign rxd_s = rxd_sync[1];

  assign half_done = (baud_cnt == HALF_LAST);
  assign bit_done  = (baud_cnt == BIT_LAST);
  assign pop_c     = uart_rdreq && !uart_empty;

`ifdef UART_RX_PARITY_EN
  logic par_en_c;
  logic par_bit_q;

  // Parity bit captured in the PARITY state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_bit_q <= 1'b0;
    else if (par_en_c) par_bit_q <= rxd_s;
  end

  // Even parity: data plus parity bit carry an even number of ones.
  assign par_ok = ~(^{shift_q, par_bit_q});
`else
  assign par_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rxd_s) state_d = ST_START;
      ST_START:     if (half_done) state_d = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bit_done && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (bit_done) state_d = ST_STOP;
`endif
      ST_STOP:      if (bit_done) state_d = (rxd_s && par_ok) ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxd_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    cnt_clr_c  = 1'b0;
    shift_en_c = 1'b0;
    good_c     = 1'b0;
    bad_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_c   = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  cnt_clr_c = 1'b1;
      ST_START: cnt_clr_c = half_done;
      ST_DATA: begin
        cnt_clr_c  = bit_done;
        shift_en_c = bit_done;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_clr_c = bit_done;
        par_en_c  = bit_done;
      end
`endif
      ST_STOP: begin
        good_c = bit_done && rxd_s && par_ok;
        bad_c  = bit_done && !(rxd_s && par_ok);
      end
      default: ;
    endcase
  end

  // Baud counter, bit counter, shift register and registered push/status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      baud_cnt <= cnt_clr_c ? '0 : baud_cnt + CNT_W'(1);
      if (state_q == ST_IDLE) bit_cnt <= '0;
      else if (shift_en_c)    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (shift_en_c) shift_q <= {rxd_s, shift_q[UART_DATA_W-1:1]};
      // A pop in the stop-sample cycle makes room for next cycle's push.
      push_q    <= good_c && (!fifo_full || pop_c);
      overrun   <= good_c && fifo_full && !pop_c;
      frame_err <= bad_c;
    end
  end

  // shift_q stays stable for the push cycle: the next frame's first shift is
  // at least half a bit period away.
  sync_fifo #(
    .WIDTH      (UART_DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (uart_rdreq),
    .head_c    (uart_in),
    .full_c    (fifo_full),
    .empty_c   (uart_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo at 16 clocks per bit.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam int LAT = 171;
`else
  localparam int NB  = 10;
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       uart_rdreq;
  logic [7:0] uart_in;
  logic       uart_empty;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int t0      = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .uart_rdreq (uart_rdreq),
    .uart_in    (uart_in),
    .uart_empty (uart_empty),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (overrun === 1'b1)   ov_cnt = ov_cnt + 1;
  end

  function automatic logic [15:0] frame_bits(input logic [7:0] b, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {5'b0, stop, ^b, b, 1'b0};
`else
    return {6'b0, stop, b, 1'b0};
`endif
  endfunction

  // bits[0] is the start bit; the last bit is held a full bit time.
  task automatic send_bits(input logic [15:0] bits, input int n, input logic pop_at_stop);
    @(posedge clk); #1; rxd = bits[0]; t0 = cyc;
    for (int i = 1; i < n; i++) begin
      repeat (CPB) @(posedge clk); #1; rxd = bits[i];
    end
    if (pop_at_stop) begin
      repeat (9) @(posedge clk); #1; uart_rdreq = 1'b1;
      @(posedge clk); #1; uart_rdreq = 1'b0;
      repeat (6) @(posedge clk); #1;
    end else begin
      repeat (CPB) @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(frame_bits(b, 1'b1), NB, 1'b0);
  endtask

  task automatic pop_one();
    @(posedge clk); #1; uart_rdreq = 1'b1;
    @(posedge clk); #1; uart_rdreq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; uart_rdreq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", uart_empty); end
    vectors++; if (uart_in !== 8'h00) begin errors++; $display("FAIL reset_uart_in: got %h want 00", uart_in); end
    vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_latency();
    int lat;
    lat = -1;
    fork
      send_frame(8'hA5);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (uart_empty === 1'b0) begin lat = cyc - t0; break; end
        end
      end
    join
    vectors++; if (lat != LAT) begin errors++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
    vectors++; if (uart_in !== 8'hA5) begin errors++; $display("FAIL latency_data: got %h want a5", uart_in); end
    pop_one();
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL latency_pop_empty: got %b want 1", uart_empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [3];
    exp_v = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) send_frame(exp_v[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL b2b_empty%0d: got %b want 0", i, uart_empty); end
      vectors++; if (uart_in !== exp_v[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, uart_in, exp_v[i]); end
      pop_one();
      @(negedge clk);
    end
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: got %b want 1", uart_empty); end
    pop_one();
    pop_one();
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL empty_rdreq: got %b want 1", uart_empty); end
    send_frame(8'h5A);
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL post_empty_rdreq_empty: got %b want 0", uart_empty); end
    vectors++; if (uart_in !== 8'h5A) begin errors++; $display("FAIL post_empty_rdreq_data: got %h want 5a", uart_in); end
    pop_one();
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL post_empty_rdreq_pop: got %b want 1", uart_empty); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 16; i++) send_frame(8'(i));
    vectors++; if (ov_cnt != ov0) begin errors++; $display("FAIL overrun_early: got %0d pulses want 0", ov_cnt - ov0); end
    send_frame(8'h11);
    @(negedge clk);
    vectors++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_count: got %0d pulses want 1", ov_cnt - ov0); end
    vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL overrun_empty: got %b want 0", uart_empty); end
    vectors++; if (uart_in !== 8'h01) begin errors++; $display("FAIL overrun_head: got %h want 01", uart_in); end
  endtask

  // Starts full with 0x01..0x10; the pop at the stop sample removes 0x01.
  task automatic test_full_pop();
    int         ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    send_bits(frame_bits(8'h99, 1'b1), NB, 1'b1);
    @(negedge clk);
    vectors++; if (ov_cnt != ov0) begin errors++; $display("FAIL full_pop_overrun: got %0d pulses want 0", ov_cnt - ov0); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 2) : 8'h99;
      vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL full_pop_empty%0d: got %b want 0", i, uart_empty); end
      vectors++; if (uart_in !== exp) begin errors++; $display("FAIL full_pop_data%0d: got %h want %h", i, uart_in, exp); end
      pop_one();
      @(negedge clk);
    end
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL full_pop_drained: got %b want 1", uart_empty); end
  endtask

  task automatic test_glitch_break();
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk); #1; rxd = 1'b0;
    repeat (4) @(posedge clk); #1; rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    vectors++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", uart_empty); end
    send_bits(frame_bits(8'h55, 1'b0), NB, 1'b0);
    repeat (100) @(posedge clk); #1; rxd = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL break_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL break_empty: got %b want 1", uart_empty); end
    send_frame(8'h55);
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL after_break_empty: got %b want 0", uart_empty); end
    vectors++; if (uart_in !== 8'h55) begin errors++; $display("FAIL after_break_data: got %h want 55", uart_in); end
    vectors++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL after_break_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
    pop_one();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11);
    send_frame(8'h22);
    send_frame(8'h33);
    @(negedge clk);
    vectors++; if (uart_in !== 8'h11) begin errors++; $display("FAIL prereset_head: got %h want 11", uart_in); end
    fork
      send_frame(8'h44);
      begin
        repeat (60) @(posedge clk); #1; rst = 1'b1;
        #1;
        vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b want 1", uart_empty); end
        vectors++; if (uart_in !== 8'h00) begin errors++; $display("FAIL midreset_uart_in: got %h want 00", uart_in); end
      end
    join
    repeat (3) @(posedge clk); #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    send_frame(8'h81);
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b0) begin errors++; $display("FAIL postreset_empty: got %b want 0", uart_empty); end
    vectors++; if (uart_in !== 8'h81) begin errors++; $display("FAIL postreset_data: got %h want 81", uart_in); end
    pop_one();
    @(negedge clk);
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL postreset_pop: got %b want 1", uart_empty); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt;
    // 0x81 has even weight, so the correct parity bit is 0; send 1.
    send_bits({5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, NB, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL parity_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
    vectors++; if (uart_empty !== 1'b1) begin errors++; $display("FAIL parity_empty: got %b want 1", uart_empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_full_pop();
    test_glitch_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive side of the core's UART port: oversamples the `rxd` line, deserializes 8N1 frames (optionally 8E1), and buffers completed bytes in a show-ahead FIFO. The CPU memory unit drains it over the existing `uart_rdreq` / `uart_empty` / `uart_in` handshake. Sits between the board RX pin and the core's memory-mapped UART read path.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); must be ≥ 8.
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).
- `clk` in 1, system clock; all logic on posedge.
- `rst` in 1, asynchronous, active-high reset.
- `rxd` in 1, asynchronous serial line; idles high.
- `uart_rdreq` in 1, pop request from the core; one byte per asserted cycle.
- `uart_in` out 8, FIFO head byte; valid while `uart_empty`=0.
- `uart_empty` out 1, FIFO empty.
- `frame_err` out 1, one-cycle pulse when the stop bit (or parity) is bad.
- `overrun` out 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1); the FSM sees only the synchronized value.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: synced `rxd`=0 → START, bit counter cleared.
- START: after `CLKS_PER_BIT/2` cycles, resample; 0 → DATA; 1 → IDLE (glitch rejected, no pulse).
- DATA: sample every `CLKS_PER_BIT` cycles, LSB first into the shift register; after bit 7 → PARITY or STOP.
- STOP: sample after `CLKS_PER_BIT` cycles. 1 and parity OK → push byte, → IDLE. Otherwise pulse `frame_err`, discard the byte, → WAIT_HIGH.
- WAIT_HIGH: stay until synced `rxd`=1, then → IDLE. A held break produces exactly one `frame_err`.
- FIFO: show-ahead. `uart_in` is the head combinationally from storage. `uart_rdreq` while empty is ignored; pointers do not move.
- Push while full without a same-cycle pop: byte dropped, `overrun` pulses, FIFO contents unchanged.
- Push and pop in the same cycle while full: both succeed; count stays at full.
- Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- Pointers are `DEPTH_LOG2`+1 bits wide and wrap naturally; empty when equal, full when MSBs differ and the rest are equal.

## Timing
- Reset values: `uart_empty`=1, `uart_in`=0 (storage cleared), `frame_err`=0, `overrun`=0, FSM=IDLE, pointers=0.
- Reset mid-frame: the partial byte is lost and buffered bytes are discarded.
- Latency from the `rxd` start falling edge to `uart_empty` falling:
  - 2 sync cycles + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycle for the push register.
  - PARITY adds one more `CLKS_PER_BIT`.
- Pop: `uart_rdreq` high at edge N → `uart_in` shows the next entry and `uart_empty` updates after edge N.
- `frame_err` and `overrun` are registered, high for exactly the cycle after the stop-bit sample.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. PARITY state samples a 9th bit. Even-parity mismatch is treated like a bad stop bit: `frame_err` pulses and the byte is discarded.
- Undefined: 8N1, no PARITY state. Port list is identical in both builds.

## Structure
- `uart_pkg`:
  - FSM state enum
  - `UART_DATA_W`=8
  - `UART_DEFAULT_CLKS_PER_BIT`=434
- Sub-module `sync_fifo`: parameterized width/depth, show-ahead, push/pop/full/empty. Reusable by a future TX path.
- Top holds the synchronizer, baud counter, shift register and FSM.

## Test plan
- `CLKS_PER_BIT`=16. Send 0xA5 8N1 → `uart_empty` falls 2+8+144+1=155 cycles after the start edge; `uart_in`=0xA5. One `uart_rdreq` → `uart_empty`=1.
- Send 0x00, 0xFF, 0x3C back-to-back with no rdreq → three entries in order. Pop 3 times → 0x00, 0xFF, 0x3C, then empty. Further rdreq has no effect.
- Send 17 bytes 0x01..0x11 with no pops → `overrun` pulses once (on 0x11). Pops return 0x01..0x10.
- 4-cycle low glitch on idle `rxd` → no push, no `frame_err`. Frame 0x55 with stop bit 0, then line held low 100 cycles → one `frame_err`, FIFO empty. The next valid 0x55 is received.
- Full FIFO with rdreq asserted on the stop-sample push cycle → no `overrun`, still full, new byte at the tail.
- Assert `rst` mid-DATA with 3 bytes buffered → `uart_empty`=1 immediately. After release, 0x81 is received correctly. With `UART_RX_PARITY_EN`, a 0x81 frame with wrong parity → `frame_err`, no push.
